// File: rtl/bcd_run_counter.sv
// Button conditioning, count-rate tick and run/pause FSM driving a mod-1000
// up/down count held as three cascaded BCD digits for the 7-segment scan stage.
module bcd_run_counter #(
   parameter int unsigned TICK_DIV        = 100_000_000,
   parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic       clk_100Mhz,
   input  logic       reset,
   input  logic       btn_run,
   input  logic       btn_clr,
   input  logic       up_down,
   output logic [3:0] digit0,
   output logic [3:0] digit1,
   output logic [3:0] digit2,
   output logic       running,
   output logic       tick
);
   localparam int unsigned DBW = $clog2(DEBOUNCE_CYCLES);
   localparam int unsigned TDW = $clog2(TICK_DIV);
   localparam logic [DBW-1:0] DB_LAST  = DBW'(DEBOUNCE_CYCLES - 1);
   localparam logic [TDW-1:0] DIV_LAST = TDW'(TICK_DIV - 1);

   typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

   function automatic logic [3:0] bcd_next(input logic [3:0] d, input logic up);
      if (up) return (d == 4'd9) ? 4'd0 : d + 4'd1;
      else    return (d == 4'd0) ? 4'd9 : d - 4'd1;
   endfunction

   function automatic logic bcd_wrap(input logic [3:0] d, input logic up);
      return up ? (d == 4'd9) : (d == 4'd0);
   endfunction

   // Bit order in the synchroniser: {up_down, btn_clr, btn_run}
   logic [2:0] meta_q, sync_q;

   always_ff @(posedge clk_100Mhz) begin
      if (reset) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= {up_down, btn_clr, btn_run};
         sync_q <= meta_q;
      end
   end

   logic [1:0] press;

   for (genvar b = 0; b < 2; b++) begin : g_db
      logic [DBW-1:0] cnt_q, cnt_d;
      logic           lvl_q, lvl_d, lvl_prev_q;

      always_comb begin
         cnt_d = '0;
         lvl_d = lvl_q;
         if (sync_q[b] != lvl_q) begin
            if (cnt_q == DB_LAST) lvl_d = sync_q[b];
            else                  cnt_d = cnt_q + 1'b1;
         end
      end

      always_ff @(posedge clk_100Mhz) begin
         if (reset) begin
            cnt_q      <= '0;
            lvl_q      <= 1'b0;
            lvl_prev_q <= 1'b0;
         end else begin
            cnt_q      <= cnt_d;
            lvl_q      <= lvl_d;
            lvl_prev_q <= lvl_q;
         end
      end

      assign press[b] = lvl_q & ~lvl_prev_q;
   end

   logic run_press, clr_press, dir_up;
   assign run_press = press[0];
   assign clr_press = press[1];
   assign dir_up    = sync_q[2];

   state_t         state_q, state_d;
   logic [TDW-1:0] div_q, div_d;
   logic [3:0]     d0_q, d1_q, d2_q, d0_d, d1_d, d2_d;
   logic           running_q;

   assign tick = (state_q == RUN) && (div_q == DIV_LAST);

   always_comb begin
      state_d = state_q;
      if (clr_press) begin
         state_d = IDLE;
      end else if (run_press) begin
         case (state_q)
            IDLE:    state_d = RUN;
            RUN:     state_d = PAUSE;
            PAUSE:   state_d = RUN;
            default: state_d = IDLE;
         endcase
      end
   end

   // Clear beats a coincident tick; carries ripple through all digits in one edge
   always_comb begin
      div_d = div_q;
      d0_d  = d0_q;
      d1_d  = d1_q;
      d2_d  = d2_q;
      if (clr_press) begin
         div_d = '0;
         d0_d  = 4'd0;
         d1_d  = 4'd0;
         d2_d  = 4'd0;
      end else if (state_q == RUN) begin
         div_d = tick ? '0 : div_q + 1'b1;
         if (tick) begin
            d0_d = bcd_next(d0_q, dir_up);
            if (bcd_wrap(d0_q, dir_up)) begin
               d1_d = bcd_next(d1_q, dir_up);
               if (bcd_wrap(d1_q, dir_up)) d2_d = bcd_next(d2_q, dir_up);
            end
         end
      end
   end

   always_ff @(posedge clk_100Mhz) begin
      if (reset) begin
         state_q   <= IDLE;
         div_q     <= '0;
         d0_q      <= 4'd0;
         d1_q      <= 4'd0;
         d2_q      <= 4'd0;
         running_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         div_q     <= div_d;
         d0_q      <= d0_d;
         d1_q      <= d1_d;
         d2_q      <= d2_d;
         running_q <= (state_d == RUN);
      end
   end

   assign digit0  = d0_q;
   assign digit1  = d1_q;
   assign digit2  = d2_q;
   assign running = running_q;

endmodule

// File: tb/tb_bcd_run_counter.sv
// Directed bench for bcd_run_counter with TICK_DIV=4, DEBOUNCE_CYCLES=3.
module tb_bcd_run_counter;
   localparam int TD = 4;
   localparam int DB = 3;

   logic       clk = 1'b0;
   logic       reset, btn_run, btn_clr, up_down;
   logic [3:0] digit0, digit1, digit2;
   logic       running, tick;
   logic [11:0] digits;

   always #5 clk = ~clk;
   assign digits = {digit2, digit1, digit0};

   bcd_run_counter #(.TICK_DIV(TD), .DEBOUNCE_CYCLES(DB)) dut (
      .clk_100Mhz(clk),
      .reset     (reset),
      .btn_run   (btn_run),
      .btn_clr   (btn_clr),
      .up_down   (up_down),
      .digit0    (digit0),
      .digit1    (digit1),
      .digit2    (digit2),
      .running   (running),
      .tick      (tick)
   );

   typedef struct {
      bit          up;
      int          n;
      logic [11:0] exp;
   } vec_t;

   vec_t tv [15];
   int   n_chk = 0, n_pass = 0;
   int   cyc_n = 0, last_tick = -1, gap_bad = 0;

   task automatic check(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic cyc();
      @(posedge clk);
      #2;
      cyc_n++;
   endtask

   // Returns at the sample where tick is high, before the edge that consumes it
   task automatic wait_tick_seen();
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 5 * TD; i++) begin
         cyc();
         if (tick === 1'b1) begin
            seen = 1'b1;
            break;
         end
      end
      check("tick_arrives", int'(seen), 1);
      if (seen) begin
         if (last_tick >= 0 && (cyc_n - last_tick) != TD) gap_bad++;
         last_tick = cyc_n;
      end
   endtask

   task automatic wait_tick();
      wait_tick_seen();
      cyc();
   endtask

   task automatic run_vecs(input int lo, input int hi);
      for (int i = lo; i <= hi; i++) begin
         up_down = tv[i].up;
         gap_bad = 0;
         for (int k = 0; k < tv[i].n; k++) wait_tick();
         check($sformatf("vec%0d_digits", i), int'(digits), int'(tv[i].exp));
         check($sformatf("vec%0d_tick_gap", i), gap_bad, 0);
      end
   endtask

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
      $fatal(1);
   end

   initial begin
      int start, bad;
      tv[0]  = '{1'b1, 5,   12'h009};
      tv[1]  = '{1'b1, 1,   12'h010};
      tv[2]  = '{1'b1, 46,  12'h056};
      tv[3]  = '{1'b1, 98,  12'h099};
      tv[4]  = '{1'b1, 1,   12'h100};
      tv[5]  = '{1'b1, 898, 12'h998};
      tv[6]  = '{1'b1, 1,   12'h999};
      tv[7]  = '{1'b1, 1,   12'h000};
      tv[8]  = '{1'b0, 1,   12'h999};
      tv[9]  = '{1'b0, 1,   12'h998};
      tv[10] = '{1'b0, 898, 12'h100};
      tv[11] = '{1'b0, 1,   12'h099};
      tv[12] = '{1'b0, 90,  12'h009};
      tv[13] = '{1'b0, 9,   12'h000};
      tv[14] = '{1'b0, 1,   12'h999};

      // Reset with both buttons held
      reset = 1'b1; btn_run = 1'b1; btn_clr = 1'b1; up_down = 1'b1;
      for (int i = 0; i < 2; i++) begin
         cyc();
         check("rst_digits", int'(digits), 0);
         check("rst_running", int'(running), 0);
         check("rst_tick", int'(tick), 0);
      end
      reset = 1'b0;
      bad = 0;
      for (int i = 0; i < 12; i++) begin
         cyc();
         if (running !== 1'b0 || tick !== 1'b0 || digits !== 12'h000) bad++;
      end
      check("held_through_reset_quiet", bad, 0);
      btn_run = 1'b0; btn_clr = 1'b0;
      repeat (8) cyc();

      // Two-cycle glitch is rejected
      btn_run = 1'b1;
      cyc(); cyc();
      btn_run = 1'b0;
      repeat (10) cyc();
      check("glitch_running", int'(running), 0);

      // Clean press: state visible after edge 6, first tick edge 4 after rise
      btn_run = 1'b1;
      repeat (5) cyc();
      check("press_edge5_running", int'(running), 0);
      cyc();
      check("press_edge6_running", int'(running), 1);
      btn_run = 1'b0;
      start = cyc_n;
      wait_tick();
      check("first_tick_latency", cyc_n - start, TD);
      check("first_tick_digits", int'(digits), 12'h001);

      // Pause lands one cycle after the 002->003 tick, so the divider holds 1
      wait_tick_seen();
      btn_run = 1'b1;
      wait_tick();
      check("pre_pause_running", int'(running), 1);
      check("pre_pause_digits", int'(digits), 12'h003);
      cyc();
      check("pause_running", int'(running), 0);
      btn_run = 1'b0;
      bad = 0;
      for (int i = 0; i < 20; i++) begin
         cyc();
         if (tick !== 1'b0 || digits !== 12'h003 || running !== 1'b0) bad++;
      end
      check("pause_frozen", bad, 0);

      btn_run = 1'b1;
      repeat (5) cyc();
      check("resume_edge5_running", int'(running), 0);
      cyc();
      check("resume_edge6_running", int'(running), 1);
      btn_run = 1'b0;
      start = cyc_n;
      last_tick = -1;
      wait_tick();
      check("resume_tick_latency", cyc_n - start, TD - 1);
      check("resume_digits", int'(digits), 12'h004);

      run_vecs(0, 2);

      // Run and clear debounce together; their press lands on the 057->058 tick
      cyc(); cyc();
      btn_run = 1'b1; btn_clr = 1'b1;
      cyc(); cyc();
      check("pre_clear_digits", int'(digits), 12'h057);
      check("pre_clear_running", int'(running), 1);
      cyc(); cyc(); cyc();
      check("clear_cycle_tick", int'(tick), 1);
      check("clear_cycle_running", int'(running), 1);
      cyc();
      check("clear_digits", int'(digits), 0);
      check("clear_running", int'(running), 0);
      check("clear_tick", int'(tick), 0);
      btn_run = 1'b0; btn_clr = 1'b0;
      bad = 0;
      for (int i = 0; i < 10; i++) begin
         cyc();
         if (tick !== 1'b0 || digits !== 12'h000 || running !== 1'b0) bad++;
      end
      check("idle_after_clear", bad, 0);

      btn_run = 1'b1;
      repeat (6) cyc();
      check("rerun_running", int'(running), 1);
      btn_run = 1'b0;
      start = cyc_n;
      last_tick = -1;
      wait_tick();
      check("rerun_tick_latency", cyc_n - start, TD);
      check("rerun_digits", int'(digits), 12'h001);

      run_vecs(3, 14);

      // Reset in RUN takes effect on the same edge
      reset = 1'b1;
      cyc();
      check("midrst_digits", int'(digits), 0);
      check("midrst_running", int'(running), 0);
      check("midrst_tick", int'(tick), 0);
      reset = 1'b0;
      repeat (TD + 2) cyc();
      check("post_midrst_digits", int'(digits), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/bcd_run_counter.md
# bcd_run_counter

Upstream control-and-count stage for the Basys3 three-digit display path. It debounces the run/pause and clear pushbuttons and generates the count-rate tick. It keeps a mod-1000 up/down count as three BCD digits. The digits feed the 7-segment scan stage directly, so the scan stage no longer needs binary-to-decimal division.

## Interface
- `TICK_DIV`, default 100_000_000: clock cycles per count step (1 Hz at 100 MHz); must be ≥ 2.
- `DEBOUNCE_CYCLES`, default 1_000_000: consecutive stable cycles required to accept a button level (10 ms); must be ≥ 2.
- `clk_100Mhz`, in, 1: the single clock; all logic is on its rising edge.
- `reset`, in, 1: synchronous, active-high; overrides all other inputs.
- `btn_run`, in, 1: raw asynchronous run/pause pushbutton, active-high.
- `btn_clr`, in, 1: raw asynchronous clear pushbutton, active-high.
- `up_down`, in, 1: raw asynchronous slide switch; 1 = count up, 0 = count down.
- `digit0`, out, 4: BCD ones digit, 0–9.
- `digit1`, out, 4: BCD tens digit, 0–9.
- `digit2`, out, 4: BCD hundreds digit, 0–9.
- `running`, out, 1: high while the FSM is in RUN.
- `tick`, out, 1: one-cycle pulse marking each count step.

## Operation
- **Synchronisers:** `btn_run`, `btn_clr` and `up_down` each pass through a 2-flop synchroniser. Nothing downstream uses the raw inputs.
- **Debouncer (one per button):**
  - A counter increments on every cycle where the synchronised level differs from the debounced level.
  - On the cycle the counter equals `DEBOUNCE_CYCLES`-1 while still mismatched, the debounced level takes the new value and the counter clears.
  - Any cycle with a match clears the counter, so glitches shorter than `DEBOUNCE_CYCLES` cycles are ignored.
- **Press pulse:** debounced level AND NOT (debounced level registered one cycle earlier). Exactly one cycle per accepted press. Releases generate nothing.
- **FSM states:** IDLE (reset state), RUN, PAUSE.
  - `clr_press` in any state → IDLE, digits forced to 000, tick divider cleared.
  - `run_press` in IDLE → RUN, with the divider starting from 0.
  - `run_press` in RUN → PAUSE.
  - `run_press` in PAUSE → RUN, with the divider resuming from its held value.
  - If `clr_press` and `run_press` occur in the same cycle, clear wins and the next state is IDLE.
- **Tick divider:** counts 0..`TICK_DIV`-1 only in RUN and holds in IDLE/PAUSE.
  - `tick` = (state==RUN) AND (divider==`TICK_DIV`-1). It is combinational from registers.
  - The divider wraps to 0 on that same edge.
- **Counting:** on each edge where `tick`=1, the digits step by ±1 per the synchronised `up_down` sampled that cycle.
  - Each digit is a cascaded BCD digit; a lower-digit carry/borrow ripples within the same cycle.
  - Up: 9→0 carries into the next digit; 999→000.
  - Down: 0→9 borrows from the next digit; 000→999.
  - A digit value above 9 never appears.
- **Outputs:** digits, `running` and FSM state are registered. `running` = (state==RUN).

## Timing
- **Reset:** while `reset`=1 at an edge, the next state is: digits 000, `running`=0, `tick`=0, FSM IDLE, all debounce/divider counters 0, debounced levels 0, synchroniser flops 0.
- **Mid-operation reset:** a reset asserted in RUN or PAUSE takes effect on the same edge. A button held through reset release is treated as a new press once it passes the debounce window.
- **Press latency:** with the raw button high and stable from edge 0, the state change is visible after edge 2+`DEBOUNCE_CYCLES`+1.
  - Edges 1–2: synchroniser.
  - Edges 3..`DEBOUNCE_CYCLES`+2: debouncer.
  - Following edge: FSM update.
- **Count latency:** digits change on the edge where `tick` is sampled high and are visible in the next cycle.
  - In uninterrupted RUN, ticks are exactly `TICK_DIV` cycles apart.
  - The first tick after IDLE→RUN comes `TICK_DIV` cycles after `running` rises.
- **Pause/resume:** no tick while paused. After resume, the next tick arrives after the remaining cycles (`TICK_DIV` minus the held divider value).
- **Clear on a tick cycle:** if `clr_press` and `tick` occur in the same cycle, clear wins and the digits become 000.

## Test plan
All scenarios use `TICK_DIV`=4 and `DEBOUNCE_CYCLES`=3.
1. Assert `reset` for 2 cycles with the buttons asserted → digits 000, `running`=0, `tick`=0 throughout, and nothing happens until the buttons are released and re-pressed.
2. Hold `btn_run` high from edge 0 → `running`=1 after edge 6. With `up_down`=1, `tick` pulses every 4 cycles and the digits show 001, 002, …. Pulse `btn_run` high for 2 cycles only → no state change.
3. Preload to 998 by running up; let two more ticks occur → digits 999, then 000. Switch to down; next tick → 999; then 998.
4. Run to 009 with up → the next tick shows 010 (tens carry). Run from 099 → 100.
5. In RUN, pause 1 cycle after a tick, wait 20 cycles → no `tick` and digits frozen. Resume → the first `tick` comes 3 cycles after `running` rises.
6. Let `btn_run` and `btn_clr` debounce in the same cycle while in RUN at 057 → IDLE, digits 000, `running`=0. A later `btn_run` press → RUN, with the first tick 4 cycles after `running` rises.
